// File: rtl/img_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : img_frame_sequencer
//  Purpose  : Sequences one grayscale frame out of a frame-buffer read port
//             into a vsync/href/gray streaming pipeline. Generates the vsync
//             envelope, per-line href bursts, programmable blanking and
//             linear row-major read addresses.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             start, cont, abort  - frame request, continuous mode, abort
//             rd_en, rd_addr      - frame-buffer read request
//             rd_data             - read data, valid 1 cycle after rd_en
//             post_img_vsync/href/gray - streaming outputs (1-cycle latency)
//             busy, done, frame_cnt    - status
//  Revision : 1.0 - initial release
// ============================================================================
module img_frame_sequencer #(
  parameter int IMG_H_DISP = 640,
  parameter int IMG_V_DISP = 480,
  parameter int ADDR_W     = 19,
  parameter int FRONT_CYC  = 10,
  parameter int HBLANK_CYC = 10,
  parameter int BACK_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              post_img_vsync,
  output logic              post_img_href,
  output logic [7:0]        post_img_gray,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  // Counter widths, floored at 1 bit so degenerate sizes still elaborate.
  localparam int c_col_w   = (IMG_H_DISP > 1) ? $clog2(IMG_H_DISP) : 1;
  localparam int c_row_w   = (IMG_V_DISP > 1) ? $clog2(IMG_V_DISP) : 1;
  localparam int c_blk_max = (FRONT_CYC > HBLANK_CYC)
                           ? ((FRONT_CYC > BACK_CYC) ? FRONT_CYC : BACK_CYC)
                           : ((HBLANK_CYC > BACK_CYC) ? HBLANK_CYC : BACK_CYC);
  localparam int c_blk_w   = (c_blk_max > 1) ? $clog2(c_blk_max) : 1;

  localparam logic [c_col_w-1:0] c_col_last    = c_col_w'(IMG_H_DISP - 1);
  localparam logic [c_row_w-1:0] c_row_last    = c_row_w'(IMG_V_DISP - 1);
  localparam logic [c_blk_w-1:0] c_front_last  = c_blk_w'(FRONT_CYC - 1);
  localparam logic [c_blk_w-1:0] c_hblank_last = c_blk_w'(HBLANK_CYC - 1);
  localparam logic [c_blk_w-1:0] c_back_last   = c_blk_w'(BACK_CYC - 1);
  localparam logic [ADDR_W-1:0]  c_addr_last   = ADDR_W'(IMG_H_DISP * IMG_V_DISP - 1);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_front  = 3'd1;
  localparam logic [2:0] c_line   = 3'd2;
  localparam logic [2:0] c_hblank = 3'd3;
  localparam logic [2:0] c_back   = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [c_col_w-1:0] r_col;
  logic [c_row_w-1:0] r_row;
  logic [c_blk_w-1:0] r_blk;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_cont_pending;
  logic               r_vsync_d;
  logic               r_href_d;
  logic               r_done;
  logic [15:0]        r_frame_cnt;

  logic w_busy;
  logic w_rd_en;
  logic w_int_vsync;
  logic w_blk_last;
  logic w_line_end;
  logic w_frame_end;
  logic w_enter_front;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Terminal count of the blanking counter for whichever blanking state is live.
  always_comb begin
    w_blk_last = 1'b0;
    case (r_state)
      c_front:  w_blk_last = (r_blk == c_front_last);
      c_hblank: w_blk_last = (r_blk == c_hblank_last);
      c_back:   w_blk_last = (r_blk == c_back_last);
      default:  w_blk_last = 1'b0;
    endcase
  end

  assign w_line_end = (r_col == c_col_last);

  // --------------------------------------------------------------------------
  // FSM: next-state logic. abort overrides everything; in IDLE it also
  // suppresses a simultaneous start or a pending continuous re-arm.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (abort) begin
      w_state_next = c_idle;
    end else begin
      case (r_state)
        c_idle:   if (start || r_cont_pending) w_state_next = c_front;
        c_front:  if (w_blk_last) w_state_next = c_line;
        c_line:   if (w_line_end) w_state_next = (r_row == c_row_last) ? c_back : c_hblank;
        c_hblank: if (w_blk_last) w_state_next = c_line;
        c_back:   if (w_blk_last) w_state_next = c_idle;
        default:  w_state_next = c_idle;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy      = (r_state != c_idle);
    w_rd_en     = (r_state == c_line);
    w_int_vsync = (r_state != c_idle);
  end

  assign w_frame_end   = (r_state == c_back) && w_blk_last && !abort;
  assign w_enter_front = (r_state == c_idle) && (w_state_next == c_front);

  // --------------------------------------------------------------------------
  // Datapath: counters, address, status and output alignment registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col          <= '0;
      r_row          <= '0;
      r_blk          <= '0;
      r_addr         <= '0;
      r_cont_pending <= 1'b0;
      r_vsync_d      <= 1'b0;
      r_href_d       <= 1'b0;
      r_done         <= 1'b0;
      r_frame_cnt    <= '0;
    end else begin
      // Blanking counter restarts on every state change.
      if (w_state_next != r_state) begin
        r_blk <= '0;
      end else if (r_state == c_front || r_state == c_hblank || r_state == c_back) begin
        r_blk <= r_blk + 1'b1;
      end

      // Entering FRONT rewinds the frame, which also cleans up after an abort.
      if (w_enter_front) begin
        r_col  <= '0;
        r_row  <= '0;
        r_addr <= '0;
      end else if (r_state == c_line) begin
        r_col <= w_line_end ? '0 : r_col + 1'b1;
        if (w_line_end) begin
          r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
        end
        // Hold on the final pixel so the address never leaves the frame.
        if (r_addr != c_addr_last) begin
          r_addr <= r_addr + 1'b1;
        end
      end

      // The pending flag lives for exactly the one IDLE cycle after BACK.
      if (abort && w_busy) begin
        r_cont_pending <= 1'b0;
      end else if (w_frame_end) begin
        r_cont_pending <= cont;
      end else if (r_state == c_idle) begin
        r_cont_pending <= 1'b0;
      end

      r_done <= w_frame_end;
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      r_vsync_d <= w_int_vsync;
      r_href_d  <= w_rd_en;
    end
  end

  assign rd_en          = w_rd_en;
  assign rd_addr        = r_addr;
  assign busy           = w_busy;
  assign done           = r_done;
  assign frame_cnt      = r_frame_cnt;
  assign post_img_vsync = r_vsync_d;
  assign post_img_href  = r_href_d;
  // rd_data arrives one cycle after rd_en, already aligned with the href delay.
  assign post_img_gray  = r_href_d ? rd_data : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_img_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_img_frame_sequencer
//  Purpose  : Self-checking bench for img_frame_sequencer. A small 4x3 frame
//             instance is driven from a scenario table with per-cycle
//             expected outputs queued to a scoreboard; a 64x48 instance with
//             default blanking checks whole-frame totals.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_img_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, cont, abort;
  logic start_b;

  // Small instance
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        vs, hr, busy, done;
  logic [7:0]  gray;
  logic [15:0] fcnt;

  img_frame_sequencer #(
    .IMG_H_DISP(4), .IMG_V_DISP(3), .ADDR_W(4),
    .FRONT_CYC(2), .HBLANK_CYC(3), .BACK_CYC(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .post_img_vsync(vs), .post_img_href(hr), .post_img_gray(gray),
    .busy(busy), .done(done), .frame_cnt(fcnt)
  );

  always @(posedge clk) rd_data <= {4'd0, rd_addr} + 8'h10;

  // Larger instance, default blanking
  logic        b_rd_en;
  logic [11:0] b_rd_addr;
  logic [7:0]  b_rd_data;
  logic        b_vs, b_hr, b_busy, b_done;
  logic [7:0]  b_gray;
  logic [15:0] b_fcnt;
  logic        b_abort;

  img_frame_sequencer #(
    .IMG_H_DISP(64), .IMG_V_DISP(48), .ADDR_W(12)
  ) dut_big (
    .clk(clk), .rst(rst), .start(start_b), .cont(1'b0), .abort(b_abort),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .post_img_vsync(b_vs), .post_img_href(b_hr), .post_img_gray(b_gray),
    .busy(b_busy), .done(b_done), .frame_cnt(b_fcnt)
  );

  always @(posedge clk) b_rd_data <= b_rd_addr[7:0] + 8'h10;

  typedef struct packed {
    logic        busy;
    logic        rd_en;
    logic [3:0]  addr;
    logic        vs;
    logic        hr;
    logic [7:0]  gray;
    logic        done;
    logic [15:0] fc;
  } outs_t;

  typedef struct {
    outs_t o;
    int    t;
    int    si;
  } rec_t;

  typedef struct {
    string name;
    int    len;
    int    s2;
    int    s3;
    int    cont_off;
    int    abort_at;
    int    rst_at;
    int    restart_at;
    int    exp_fc_end;
  } scen_t;

  rec_t  sb[$];
  scen_t tab[5];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    fc_exp   = 0;

  // Expected small-frame outputs, relative to a start pulse at rel=0.
  function automatic outs_t exp_frame(input int rel);
    outs_t e;
    e = '0;
    e.busy = (rel >= 1 && rel <= 21);
    e.vs   = (rel >= 2 && rel <= 22);
    e.done = (rel == 22);
    for (int r = 0; r < 3; r++) begin
      int ls;
      ls = 3 + 7 * r;
      if (rel >= ls && rel <= ls + 3) begin
        e.rd_en = 1'b1;
        e.addr  = 4'(4 * r + rel - ls);
      end
      if (rel - 1 >= ls && rel - 1 <= ls + 3) begin
        e.hr   = 1'b1;
        e.gray = 8'(8'h10 + 4 * r + rel - 1 - ls);
      end
    end
    return e;
  endfunction

  function automatic outs_t exp_at(input scen_t s, input int t);
    outs_t e;
    if (s.restart_at >= 0 && t >= s.restart_at) begin
      e = exp_frame(t - s.restart_at);
    end else if (s.rst_at >= 0 && t > s.rst_at) begin
      e = '0;
    end else if (s.abort_at >= 0 && t > s.abort_at) begin
      e = '0;
      if (t == s.abort_at + 1) begin
        e = exp_frame(t);
        e.busy  = 1'b0;
        e.rd_en = 1'b0;
        e.addr  = '0;
      end
    end else if (s.cont_off > 0 && t > 22) begin
      e = exp_frame(t - 22);
    end else begin
      e = exp_frame(t);
    end
    return e;
  endfunction

  // Scoreboard consumer: compares each queued expectation mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      rec_t  r;
      outs_t a;
      r = sb.pop_front();
      a.busy  = busy;
      a.rd_en = rd_en;
      a.addr  = r.o.rd_en ? rd_addr : 4'd0;
      a.vs    = vs;
      a.hr    = hr;
      a.gray  = gray;
      a.done  = done;
      a.fc    = fcnt;
      n_checks++;
      if (a !== r.o) begin
        n_fail++;
        $display("FAIL wave[%0d] t=%0d actual(busy rd_en addr vs href gray done fc)=%b %b %h %b %b %h %b %0d required=%b %b %h %b %b %h %b %0d",
                 r.si, r.t, a.busy, a.rd_en, a.addr, a.vs, a.hr, a.gray, a.done, a.fc,
                 r.o.busy, r.o.rd_en, r.o.addr, r.o.vs, r.o.hr, r.o.gray, r.o.done, r.o.fc);
      end
    end
  end

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          name          len  s2  s3 cont abort rst restart fc_end
    tab[0] = '{"single",       25, -1, -1,  0,   -1,  -1,   -1,    1};
    tab[1] = '{"start_busy",   25,  5, 15,  0,   -1,  -1,   -1,    2};
    tab[2] = '{"continuous",   47, -1, -1, 30,   -1,  -1,   -1,    4};
    tab[3] = '{"abort_line",   45, -1, -1,  0,   11,  -1,   20,    5};
    tab[4] = '{"reset_mid",    37, -1, -1,  0,   -1,   8,   12,    1};

    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0;
    start_b = 1'b0; b_abort = 1'b0;
    tick();
    // Reset state
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{o: '0, t: i, si: -1});
      tick();
    end
    rst = 1'b0;
    sb.push_back('{o: '0, t: 3, si: -1});
    tick();

    for (int si = 0; si < 5; si++) begin
      scen_t s;
      s = tab[si];
      for (int t = 0; t < s.len; t++) begin
        outs_t e;
        start = (t == 0) || (t == s.s2) || (t == s.s3) || (t == s.restart_at);
        cont  = (t < s.cont_off);
        abort = (t == s.abort_at);
        rst   = (s.rst_at >= 0) && (t == s.rst_at || t == s.rst_at + 1);
        e = exp_at(s, t);
        if (s.rst_at >= 0 && t > s.rst_at && (s.restart_at < 0 || t < s.restart_at))
          fc_exp = 0;
        if (e.done) fc_exp++;
        e.fc = 16'(fc_exp);
        sb.push_back('{o: e, t: t, si: si});
        tick();
      end
      start = 1'b0; cont = 1'b0; abort = 1'b0; rst = 1'b0;
      tick();
      tick();
      check({s.name, "_frame_cnt"}, fcnt, s.exp_fc_end);
      check({s.name, "_idle"}, busy, 0);
    end

    // Whole-frame totals on the 64x48 instance
    begin
      int  n_href = 0, n_vs = 0, n_done = 0, n_gray_err = 0;
      int  last_addr = -1;
      logic       prev_en = 1'b0;
      logic [11:0] prev_addr = '0;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int c = 0; c < 3700; c++) begin
        @(negedge clk);
        if (b_vs) n_vs++;
        if (b_done) n_done++;
        if (b_hr) begin
          n_href++;
          if (!prev_en || b_gray !== prev_addr[7:0] + 8'h10) n_gray_err++;
        end
        prev_en   = b_rd_en;
        prev_addr = b_rd_addr;
        if (b_rd_en) last_addr = int'(b_rd_addr);
      end
      check("big_href_cycles", n_href, 3072);
      check("big_last_addr", last_addr, 3071);
      check("big_vsync_cycles", n_vs, 10 + 3072 + 47 * 10 + 1);
      check("big_done_pulses", n_done, 1);
      check("big_gray_errors", n_gray_err, 0);
      check("big_frame_cnt", b_fcnt, 1);
      check("big_idle", b_busy, 0);
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
